// File: rtl/lod_pkg.sv
// Shared widths, FSM state type and node record for the LOD interpolation sequencer.
// Pure declarations: no latency, no flow control.
package lod_pkg;
  localparam int XW         = 10;
  localparam int YW         = 8;
  localparam int GW         = 12;
  localparam int OW         = 10;
  localparam int AW         = 4;
  localparam int NSEG_DEF   = 8;
  localparam int IP_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LAT,
    RESP
  } lod_state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } node_t;
endpackage

// File: rtl/lod_node_lut.sv
// Node position/value and segment gain register file: one write port, reads at k and k+1.
// Writes land on the clock edge; reads are combinational; the caller gates i_we.
module lod_node_lut
  import lod_pkg::*;
#(
  parameter int NSEG = NSEG_DEF
) (
  input  logic          i_clk,
  input  logic          i_rstb,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [XW-1:0] i_xpos,
  input  logic [YW-1:0] i_yval,
  input  logic [GW-1:0] i_gain,
  input  logic [AW-1:0] i_k,
  output node_t         o_node_lo,
  output node_t         o_node_hi,
  output logic [GW-1:0] o_gain
);
  node_t         r_node [0:NSEG];
  logic [GW-1:0] r_gain [0:NSEG-1];
  logic [AW-1:0] w_k_hi;

  assign w_k_hi = i_k + AW'(1);

  // Last node has no segment to its right, so its gain is never stored.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      for (int i = 0; i <= NSEG; i++) r_node[i] <= '0;
      for (int i = 0; i < NSEG; i++) r_gain[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i <= NSEG; i++) begin
        if (i_addr == AW'(i)) r_node[i] <= '{x: i_xpos, y: i_yval};
      end
      for (int i = 0; i < NSEG; i++) begin
        if (i_addr == AW'(i)) r_gain[i] <= i_gain;
      end
    end
  end

  always_comb begin
    o_node_lo = '0;
    o_node_hi = '0;
    o_gain    = '0;
    for (int i = 0; i <= NSEG; i++) begin
      if (i_k == AW'(i))    o_node_lo = r_node[i];
      if (w_k_hi == AW'(i)) o_node_hi = r_node[i];
    end
    for (int i = 0; i < NSEG; i++) begin
      if (i_k == AW'(i)) o_gain = r_gain[i];
    end
  end
endmodule

// File: rtl/lod_interp_seq.sv
// Piecewise-linear LOD sequencer: linear segment search, drives an external interpolator, returns its result.
// Latency (k+1)+(IP_LAT+1) cycles from accept; one sample in flight, result held until OUT_READY.
module lod_interp_seq
  import lod_pkg::*;
#(
  parameter int NSEG   = NSEG_DEF,
  parameter int IP_LAT = IP_LAT_DEF
) (
  input  logic          CLK,
  input  logic          RSTB,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [XW-1:0] IN_X,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [OW-1:0] OUT_VAL,
  input  logic          CFG_WE,
  input  logic [AW-1:0] CFG_ADDR,
  input  logic [XW-1:0] CFG_XPOS,
  input  logic [YW-1:0] CFG_YVAL,
  input  logic [GW-1:0] CFG_GAIN,
  output logic          CFG_ERR,
  output logic [XW-1:0] IP_CURRENT,
  output logic [GW-1:0] IP_GAIN,
  output logic [YW-1:0] IP_LEFT,
  output logic [YW-1:0] IP_RIGHT,
  input  logic [OW-1:0] IP_VAL
);
  localparam int CW = $clog2(IP_LAT + 2);

  lod_state_t    r_state;
  logic [XW-1:0] r_x;
  logic [AW-1:0] r_k;
  logic [CW-1:0] r_cnt;
  logic          r_in_rdy;
  logic          r_out_vld;
  logic [OW-1:0] r_out_val;
  logic          r_cfg_err;
  logic [XW-1:0] r_ip_cur;
  logic [GW-1:0] r_ip_gain;
  logic [YW-1:0] r_ip_left;
  logic [YW-1:0] r_ip_right;

  node_t         w_lo;
  node_t         w_hi;
  logic [GW-1:0] w_gain;
  logic          w_cfg_ok;
  logic          w_last_seg;
  logic [XW:0]   w_diff;
  logic          w_clamp_lo;
  logic          w_clamp_hi;
  logic          w_hit;

  assign w_cfg_ok   = CFG_WE && (r_state == IDLE) && (CFG_ADDR <= AW'(NSEG));
  assign w_last_seg = (r_k == AW'(NSEG - 1));

  // A borrow out of the 11-bit difference means the sample lies left of node k.
  assign w_diff     = {1'b0, r_x} - {1'b0, w_lo.x};
  assign w_clamp_lo = w_diff[XW];
  assign w_clamp_hi = w_last_seg && (r_x >= w_hi.x);
  assign w_hit      = (r_x < w_hi.x) || w_last_seg;

  lod_node_lut #(
    .NSEG (NSEG)
  ) u_lut (
    .i_clk     (CLK),
    .i_rstb    (RSTB),
    .i_we      (w_cfg_ok),
    .i_addr    (CFG_ADDR),
    .i_xpos    (CFG_XPOS),
    .i_yval    (CFG_YVAL),
    .i_gain    (CFG_GAIN),
    .i_k       (r_k),
    .o_node_lo (w_lo),
    .o_node_hi (w_hi),
    .o_gain    (w_gain)
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_in_rdy   <= 1'b1;
      r_out_vld  <= 1'b0;
      r_out_val  <= '0;
      r_cfg_err  <= 1'b0;
      r_ip_cur   <= '0;
      r_ip_gain  <= '0;
      r_ip_left  <= '0;
      r_ip_right <= '0;
    end else begin
      r_cfg_err <= CFG_WE && !w_cfg_ok;
      case (r_state)
        IDLE: begin
          if (IN_VALID && r_in_rdy) begin
            r_x      <= IN_X;
            r_k      <= '0;
            r_in_rdy <= 1'b0;
            r_state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_hit) begin
            r_cnt     <= '0;
            r_ip_gain <= w_gain;
            r_state   <= LAT;
            if (w_clamp_lo) begin
              r_ip_cur   <= '0;
              r_ip_left  <= w_lo.y;
              r_ip_right <= w_lo.y;
            end else if (w_clamp_hi) begin
              r_ip_cur   <= '0;
              r_ip_left  <= w_hi.y;
              r_ip_right <= w_hi.y;
            end else begin
              r_ip_cur   <= w_diff[XW-1:0];
              r_ip_left  <= w_lo.y;
              r_ip_right <= w_hi.y;
            end
          end else begin
            r_k <= r_k + AW'(1);
          end
        end
        LAT: begin
          // Interpolator inputs have been stable IP_LAT edges by the final count.
          if (r_cnt == CW'(IP_LAT)) begin
            r_out_val <= IP_VAL;
            r_out_vld <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (OUT_READY) begin
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign IN_READY   = r_in_rdy;
  assign OUT_VALID  = r_out_vld;
  assign OUT_VAL    = r_out_val;
  assign CFG_ERR    = r_cfg_err;
  assign IP_CURRENT = r_ip_cur;
  assign IP_GAIN    = r_ip_gain;
  assign IP_LEFT    = r_ip_left;
  assign IP_RIGHT   = r_ip_right;
endmodule
